ssd1306_spi_sink: RTL and testbench

//  Receiving end of the SSD1306 4-wire SPI link: oversamples csn/dc/sck/mosi with clk_in, assembles bytes,

---
 rtl/ssd1306_pkg.sv | 38 +++
 rtl/ssd1306_spi_sink_rx.sv | 68 ++++++
 rtl/ssd1306_spi_sink.sv | 179 +++++++++++++++++
 tb/tb_ssd1306_spi_sink.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ssd1306_pkg.sv
// SSD1306 opcodes, addressing modes, parser states and the per-opcode argument count.
package ssd1306_pkg;

  localparam logic [7:0] CMD_MEM_MODE        = 8'h20;
  localparam logic [7:0] CMD_COL_ADDR        = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR       = 8'h22;
  localparam logic [7:0] CMD_DISPLAY_OFF     = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON      = 8'hAF;
  localparam logic [7:0] CMD_PAGE_START_BASE = 8'hB0;

  typedef enum logic [1:0] {
    MODE_HORIZ = 2'd0,
    MODE_VERT  = 2'd1,
    MODE_PAGE  = 2'd2
  } addr_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ARGS = 1'b1
  } parser_state_t;

  typedef struct packed {
    logic       dc;
    logic [7:0] dat;
  } rx_byte_t;

  function automatic int cmd_arg_count(input logic [7:0] op);
    case (op)
      8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
      8'hD5, 8'hD9, 8'hDA, 8'hDB: cmd_arg_count = 1;
      8'h21, 8'h22, 8'hA3:        cmd_arg_count = 2;
      8'h29, 8'h2A:               cmd_arg_count = 5;
      8'h26, 8'h27:               cmd_arg_count = 6;
      default:                    cmd_arg_count = 0;
    endcase
  endfunction

endpackage

// File: rtl/ssd1306_spi_sink_rx.sv
// Oversampling SPI byte receiver: synchronizes csn/dc/sck/mosi and shifts mosi MSB-first on SCK rise.
// rx_vld pulses SYNC_STAGES+1 cycles after the 8th SCK rise; no backpressure, bytes are never held off.
module spi_byte_rx
  import ssd1306_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk_in,
  input  logic     reset_in,
  input  logic     csn,
  input  logic     dc,
  input  logic     sck,
  input  logic     mosi,
  output rx_byte_t rx_dat,
  output logic     rx_vld
);

  logic [SYNC_STAGES-1:0] csn_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift_q;
  logic                   sck_rise;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      csn_sync  <= '1;
      dc_sync   <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
    end else begin
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_d;

  // csn high (including its rising edge) drops any partial byte
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sck_d   <= 1'b0;
      bit_cnt <= '0;
      shift_q <= '0;
      rx_dat  <= '0;
      rx_vld  <= 1'b0;
    end else begin
      sck_d  <= sck_sync[SYNC_STAGES-1];
      rx_vld <= 1'b0;
      if (csn_sync[SYNC_STAGES-1]) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        shift_q <= {shift_q[5:0], mosi_sync[SYNC_STAGES-1]};
        if (bit_cnt == 3'd7) begin
          rx_vld     <= 1'b1;
          rx_dat.dc  <= dc_sync[SYNC_STAGES-1];
          rx_dat.dat <= {shift_q, mosi_sync[SYNC_STAGES-1]};
        end
      end
    end
  end

endmodule

// File: rtl/ssd1306_spi_sink.sv
// SSD1306 SPI sink: parses commands, tracks GDDRAM addressing, strobes pixel bytes SYNC_STAGES+2 cycles after the
// 8th SCK rise; no backpressure. `define SSD1306_SINK_STATS_EN adds data/frame counters.
module ssd1306_spi_sink
  import ssd1306_pkg::*;
#(
  parameter  int SYNC_STAGES = 2,
  parameter  int COLS        = 128,
  parameter  int PAGES       = 4,
  localparam int CW          = $clog2(COLS),
  localparam int PW          = $clog2(PAGES)
) (
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          oled_csn_in,
  input  logic          oled_dc_in,
  input  logic          oled_clk_in,
  input  logic          oled_mosi_in,
  output logic [7:0]    fb_data_out,
  output logic [CW-1:0] fb_col_out,
  output logic [PW-1:0] fb_page_out,
  output logic          fb_write_stb_out,
  output logic          cmd_stb_out,
  output logic [7:0]    cmd_byte_out,
  output logic          display_on_out,
  output logic          frame_stb_out
`ifdef SSD1306_SINK_STATS_EN
  ,
  output logic [31:0]   data_count_out,
  output logic [15:0]   frame_count_out
`endif
);

  rx_byte_t      rx_dat;
  logic          rx_vld;
  parser_state_t state;
  addr_mode_t    mode;
  logic [2:0]    args_left;
  logic [7:0]    opcode;
  logic [7:0]    first_arg;
  logic [CW-1:0] col_ptr, col_start, col_end;
  logic [PW-1:0] page_ptr, page_start, page_end;
  logic          cmd_done;
  logic [7:0]    done_op;
  logic [7:0]    col_ext;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .csn      (oled_csn_in),
    .dc       (oled_dc_in),
    .sck      (oled_clk_in),
    .mosi     (oled_mosi_in),
    .rx_dat   (rx_dat),
    .rx_vld   (rx_vld)
  );

  function automatic logic [CW-1:0] clamp_col(input logic [7:0] v);
    if (int'(v) > COLS - 1) clamp_col = CW'(COLS - 1);
    else                    clamp_col = v[CW-1:0];
  endfunction

  function automatic logic [PW-1:0] clamp_page(input logic [7:0] v);
    if (int'(v) > PAGES - 1) clamp_page = PW'(PAGES - 1);
    else                     clamp_page = v[PW-1:0];
  endfunction

  assign col_ext = 8'(col_ptr);

  // A command completes on a zero-arg opcode or on its last argument byte
  always_comb begin
    cmd_done = 1'b0;
    done_op  = rx_dat.dat;
    if (rx_vld && !rx_dat.dc) begin
      if (state == ST_IDLE) begin
        cmd_done = (cmd_arg_count(rx_dat.dat) == 0);
      end else if (args_left == 3'd1) begin
        cmd_done = 1'b1;
        done_op  = opcode;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state            <= ST_IDLE;
      mode             <= MODE_PAGE;
      args_left        <= '0;
      opcode           <= '0;
      first_arg        <= '0;
      col_ptr          <= '0;
      col_start        <= '0;
      col_end          <= CW'(COLS - 1);
      page_ptr         <= '0;
      page_start       <= '0;
      page_end         <= PW'(PAGES - 1);
      fb_data_out      <= '0;
      fb_col_out       <= '0;
      fb_page_out      <= '0;
      fb_write_stb_out <= 1'b0;
      cmd_stb_out      <= 1'b0;
      cmd_byte_out     <= '0;
      display_on_out   <= 1'b0;
      frame_stb_out    <= 1'b0;
`ifdef SSD1306_SINK_STATS_EN
      data_count_out   <= '0;
      frame_count_out  <= '0;
`endif
    end else begin
      fb_write_stb_out <= 1'b0;
      cmd_stb_out      <= 1'b0;
      frame_stb_out    <= 1'b0;
      if (rx_vld && rx_dat.dc) begin
        // Data byte also abandons any half-received command
        state            <= ST_IDLE;
        args_left        <= '0;
        fb_write_stb_out <= 1'b1;
        fb_data_out      <= rx_dat.dat;
        fb_col_out       <= col_ptr;
        fb_page_out      <= page_ptr;
`ifdef SSD1306_SINK_STATS_EN
        data_count_out   <= data_count_out + 32'd1;
`endif
        if (mode == MODE_PAGE) begin
          col_ptr <= (col_ptr == CW'(COLS - 1)) ? '0 : col_ptr + 1'b1;
        end else if (col_ptr == col_end) begin
          col_ptr <= col_start;
          if (page_ptr == page_end) begin
            page_ptr      <= page_start;
            frame_stb_out <= 1'b1;
`ifdef SSD1306_SINK_STATS_EN
            frame_count_out <= frame_count_out + 16'd1;
`endif
          end else begin
            page_ptr <= page_ptr + 1'b1;
          end
        end else begin
          col_ptr <= col_ptr + 1'b1;
        end
      end else if (rx_vld) begin
        if (state == ST_IDLE) begin
          opcode    <= rx_dat.dat;
          args_left <= 3'(cmd_arg_count(rx_dat.dat));
          if (!cmd_done) state <= ST_ARGS;
        end else begin
          first_arg <= rx_dat.dat;
          args_left <= args_left - 3'd1;
          if (cmd_done) state <= ST_IDLE;
        end
        if (cmd_done) begin
          cmd_stb_out  <= 1'b1;
          cmd_byte_out <= done_op;
          if (done_op == CMD_DISPLAY_ON) begin
            display_on_out <= 1'b1;
          end else if (done_op == CMD_DISPLAY_OFF) begin
            display_on_out <= 1'b0;
          end else if (done_op == CMD_MEM_MODE) begin
            if (rx_dat.dat[1:0] == 2'd2)      mode <= MODE_PAGE;
            else if (rx_dat.dat[1:0] != 2'd3) mode <= MODE_HORIZ;
          end else if (done_op == CMD_COL_ADDR) begin
            col_start <= clamp_col(first_arg);
            col_end   <= clamp_col(rx_dat.dat);
            col_ptr   <= clamp_col(first_arg);
          end else if (done_op == CMD_PAGE_ADDR) begin
            page_start <= clamp_page(first_arg);
            page_end   <= clamp_page(rx_dat.dat);
            page_ptr   <= clamp_page(first_arg);
          end else if (done_op[7:4] == 4'h0 && mode == MODE_PAGE) begin
            col_ptr <= clamp_col({col_ext[7:4], done_op[3:0]});
          end else if (done_op[7:4] == 4'h1 && mode == MODE_PAGE) begin
            col_ptr <= clamp_col({done_op[3:0], col_ext[3:0]});
          end else if (done_op[7:3] == CMD_PAGE_START_BASE[7:3]) begin
            page_ptr <= clamp_page({5'd0, done_op[2:0]});
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// Directed bench for ssd1306_spi_sink: SPI master driver, strobe monitor and vector table of expected writes.
module tb_ssd1306_spi_sink;

  localparam int HALF = 3;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       oled_csn_in, oled_dc_in, oled_clk_in, oled_mosi_in;
  logic [7:0] fb_data_out;
  logic [6:0] fb_col_out;
  logic [1:0] fb_page_out;
  logic       fb_write_stb_out, cmd_stb_out, display_on_out, frame_stb_out;
  logic [7:0] cmd_byte_out;
`ifdef SSD1306_SINK_STATS_EN
  logic [31:0] data_count_out;
  logic [15:0] frame_count_out;
`endif

  ssd1306_spi_sink dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .oled_csn_in      (oled_csn_in),
    .oled_dc_in       (oled_dc_in),
    .oled_clk_in      (oled_clk_in),
    .oled_mosi_in     (oled_mosi_in),
    .fb_data_out      (fb_data_out),
    .fb_col_out       (fb_col_out),
    .fb_page_out      (fb_page_out),
    .fb_write_stb_out (fb_write_stb_out),
    .cmd_stb_out      (cmd_stb_out),
    .cmd_byte_out     (cmd_byte_out),
    .display_on_out   (display_on_out),
    .frame_stb_out    (frame_stb_out)
`ifdef SSD1306_SINK_STATS_EN
    ,
    .data_count_out   (data_count_out),
    .frame_count_out  (frame_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0] d;
    logic [6:0] col;
    logic [1:0] page;
    logic       frame;
  } fb_rec_t;

  typedef struct {
    logic [7:0] b;
    int         cyc;
  } cmd_rec_t;

  typedef struct {
    logic       dc;
    logic [7:0] b;
    logic       exp_fb;
    logic [7:0] exp_d;
    logic [6:0] exp_col;
    logic [1:0] exp_page;
    logic       exp_cmd;
    logic [7:0] exp_cmd_b;
    logic       exp_disp;
  } vec_t;

  fb_rec_t  fbq[$];
  cmd_rec_t cmdq[$];
  int       cyc = 0;
  int       last_rise_cyc = 0;
  int       frame_cnt = 0;
  int       both_cnt = 0;
  int       orphan_cnt = 0;
  int       n_chk = 0;
  int       n_pass = 0;
  vec_t     vecs[15];

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (fb_write_stb_out) fbq.push_back('{fb_data_out, fb_col_out, fb_page_out, frame_stb_out});
    if (cmd_stb_out) cmdq.push_back('{cmd_byte_out, cyc});
    if (frame_stb_out) frame_cnt++;
    if (fb_write_stb_out && cmd_stb_out) both_cnt++;
    if (frame_stb_out && !fb_write_stb_out) orphan_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send_bits(input logic dc, input logic [7:0] b, input int nbits);
    oled_csn_in = 1'b0;
    oled_dc_in  = dc;
    for (int i = 7; i > 7 - nbits; i--) begin
      oled_mosi_in = b[i];
      oled_clk_in  = 1'b0;
      repeat (HALF) @(posedge clk_in);
      #1;
      oled_clk_in   = 1'b1;
      last_rise_cyc = cyc;
      repeat (HALF) @(posedge clk_in);
      #1;
    end
    oled_clk_in = 1'b0;
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    send_bits(dc, b, 8);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic clear_mon();
    fbq.delete();
    cmdq.delete();
  endtask

  initial begin
    int lat;
    reset_in     = 1'b1;
    oled_csn_in  = 1'b1;
    oled_dc_in   = 1'b0;
    oled_clk_in  = 1'b0;
    oled_mosi_in = 1'b0;

    // dc, byte, fb?, data, col, page, cmd?, cmd byte, display_on afterwards
    vecs[0]  = '{1'b0, 8'hAF, 1'b0, 8'h00, 7'h00, 2'd0, 1'b1, 8'hAF, 1'b1};
    vecs[1]  = '{1'b0, 8'h20, 1'b0, 8'h00, 7'h00, 2'd0, 1'b0, 8'h00, 1'b1};
    vecs[2]  = '{1'b0, 8'h02, 1'b0, 8'h00, 7'h00, 2'd0, 1'b1, 8'h20, 1'b1};
    vecs[3]  = '{1'b0, 8'hB2, 1'b0, 8'h00, 7'h00, 2'd0, 1'b1, 8'hB2, 1'b1};
    vecs[4]  = '{1'b0, 8'h05, 1'b0, 8'h00, 7'h00, 2'd0, 1'b1, 8'h05, 1'b1};
    vecs[5]  = '{1'b0, 8'h17, 1'b0, 8'h00, 7'h00, 2'd0, 1'b1, 8'h17, 1'b1};
    vecs[6]  = '{1'b1, 8'h11, 1'b1, 8'h11, 7'h75, 2'd2, 1'b0, 8'h00, 1'b1};
    vecs[7]  = '{1'b1, 8'h22, 1'b1, 8'h22, 7'h76, 2'd2, 1'b0, 8'h00, 1'b1};
    vecs[8]  = '{1'b1, 8'h33, 1'b1, 8'h33, 7'h77, 2'd2, 1'b0, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, 8'h0F, 1'b0, 8'h00, 7'h00, 2'd0, 1'b1, 8'h0F, 1'b1};
    vecs[10] = '{1'b1, 8'h44, 1'b1, 8'h44, 7'h7F, 2'd2, 1'b0, 8'h00, 1'b1};
    vecs[11] = '{1'b1, 8'h55, 1'b1, 8'h55, 7'h00, 2'd2, 1'b0, 8'h00, 1'b1};
    vecs[12] = '{1'b0, 8'h81, 1'b0, 8'h00, 7'h00, 2'd0, 1'b0, 8'h00, 1'b1};
    vecs[13] = '{1'b1, 8'hAA, 1'b1, 8'hAA, 7'h01, 2'd2, 1'b0, 8'h00, 1'b1};
    vecs[14] = '{1'b0, 8'hAE, 1'b0, 8'h00, 7'h00, 2'd0, 1'b1, 8'hAE, 1'b0};

    idle(3);
    @(negedge clk_in);
    check("reset_strobes", {fb_write_stb_out, cmd_stb_out, frame_stb_out, display_on_out}, 0);
    check("reset_fb", {fb_data_out, fb_col_out, fb_page_out}, 0);
    check("reset_cmd_byte", cmd_byte_out, 0);
    @(posedge clk_in);
    #1 reset_in = 1'b0;
    idle(4);

    for (int i = 0; i < 15; i++) begin
      clear_mon();
      send_byte(vecs[i].dc, vecs[i].b);
      idle(8);
      check($sformatf("vec%0d_fb_cnt", i), fbq.size(), 32'(vecs[i].exp_fb));
      if (vecs[i].exp_fb && fbq.size() > 0) begin
        check($sformatf("vec%0d_fb_data", i), fbq[0].d, vecs[i].exp_d);
        check($sformatf("vec%0d_fb_addr", i), {fbq[0].page, fbq[0].col}, {vecs[i].exp_page, vecs[i].exp_col});
        check($sformatf("vec%0d_frame", i), fbq[0].frame, 0);
      end
      check($sformatf("vec%0d_cmd_cnt", i), cmdq.size(), 32'(vecs[i].exp_cmd));
      if (vecs[i].exp_cmd && cmdq.size() > 0)
        check($sformatf("vec%0d_cmd_byte", i), cmdq[0].b, vecs[i].exp_cmd_b);
      check($sformatf("vec%0d_display_on", i), display_on_out, vecs[i].exp_disp);
      if (i == 0) begin
        lat = (cmdq.size() > 0) ? cmdq[0].cyc - last_rise_cyc : -1;
        check("cmd_latency", lat, 4);
      end
    end

    // Horizontal mode over the full 128x4 window
    clear_mon();
    send_byte(1'b0, 8'h20); send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h7F);
    send_byte(1'b0, 8'h22); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h03);
    idle(8);
    check("setup_cmd_cnt", cmdq.size(), 3);
    if (cmdq.size() == 3) check("setup_cmd_seq", {cmdq[0].b, cmdq[1].b, cmdq[2].b}, 24'h202122);
    clear_mon();
    frame_cnt = 0;
    for (int k = 0; k < 512; k++) send_byte(1'b1, 8'(k));
    idle(8);
    check("horiz_fb_cnt", fbq.size(), 512);
    for (int k = 0; k < 512 && k < fbq.size(); k++)
      check($sformatf("horiz_byte%0d", k), {fbq[k].d, fbq[k].page, fbq[k].col, fbq[k].frame},
            {8'(k), 2'(k / 128), 7'(k % 128), (k == 511) ? 1'b1 : 1'b0});
    check("horiz_frame_cnt", frame_cnt, 1);
    clear_mon();
    send_byte(1'b1, 8'h99);
    idle(8);
    check("wrap_fb_cnt", fbq.size(), 1);
    if (fbq.size() > 0) check("wrap_addr", {fbq[0].page, fbq[0].col, fbq[0].frame}, 0);

    // Partial byte abandoned by csn going high
    clear_mon();
    send_bits(1'b1, 8'hFF, 5);
    oled_csn_in = 1'b1;
    idle(6);
    send_byte(1'b1, 8'h3C);
    idle(8);
    check("partial_fb_cnt", fbq.size(), 1);
    if (fbq.size() > 0) check("partial_fb", {fbq[0].d, fbq[0].page, fbq[0].col}, {8'h3C, 2'd0, 7'd1});

    // Reset in the middle of a byte
    send_byte(1'b0, 8'hAF);
    idle(8);
    check("pre_reset_display_on", display_on_out, 1);
    send_bits(1'b1, 8'hA5, 4);
    reset_in = 1'b1;
    @(negedge clk_in);
    check("midreset_outputs", {fb_data_out, fb_col_out, fb_page_out, cmd_byte_out, display_on_out}, 0);
    @(posedge clk_in);
    #1 reset_in = 1'b0;
    oled_csn_in = 1'b1;
    idle(6);
    clear_mon();
    send_byte(1'b1, 8'h5A);
    idle(8);
    check("post_reset_fb_cnt", fbq.size(), 1);
    if (fbq.size() > 0) check("post_reset_fb", {fbq[0].d, fbq[0].page, fbq[0].col}, {8'h5A, 2'd0, 7'd0});
    oled_csn_in = 1'b1;
    idle(4);

    check("fb_cmd_overlap", both_cnt, 0);
    check("orphan_frame", orphan_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
